hazard_control: RTL

- Hazard detection and pipeline-control unit for the 5-stage RV32I pipeline; the producer-side complement to EX-stage operand forwarding.
- Detects hazards forwarding cannot resolve: load-use, taken branch/jump, data-memory wait.
- Drives hold/flush controls for the PC, IF/ID, ID/EX and EX/ME registers.
- Keeps stall and flush performance counters.

---
 rtl/hazard_control.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_control.sv
// Hazard detection and pipeline hold/flush control for a 5-stage RV32I pipeline.
// Covers load-use bubbles, taken-branch flushes and data-memory wait stalls, with perf counters.
module hazard_control #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic [4:0]        rd_ex,
  input  logic              DMRdex,
  input  logic              NextPCSrc,
  input  logic              mem_req_me,
  input  logic              mem_ready_me,
  output logic              hold_pc,
  output logic              hold_ifid,
  output logic              hold_idex,
  output logic              hold_exme,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_mewb,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [FCNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        load_ctr_q, load_ctr_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [FCNT_W-1:0] flush_cnt_q;
  logic              flush_evt;
  logic              lu_hit;
  logic              mem_wait;

  assign lu_hit = DMRdex && (rd_ex != 5'd0) &&
                  ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));
  assign mem_wait = mem_req_me && !mem_ready_me;

  always_comb begin
    hold_pc    = 1'b0;
    hold_ifid  = 1'b0;
    hold_idex  = 1'b0;
    hold_exme  = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    flush_mewb = 1'b0;
    flush_evt  = 1'b0;
    state_d    = state_q;
    load_ctr_d = load_ctr_q;

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          hold_pc    = 1'b1;
          hold_ifid  = 1'b1;
          hold_idex  = 1'b1;
          hold_exme  = 1'b1;
          flush_mewb = 1'b1;
          state_d    = MEM_WAIT;
        end else if (NextPCSrc) begin
          // The ID instruction is wrong-path, so a load-use match there is moot.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          flush_evt  = 1'b1;
        end else if (lu_hit) begin
          hold_pc    = 1'b1;
          hold_ifid  = 1'b1;
          flush_idex = 1'b1;
          if (LOAD_LAT > 1) begin
            load_ctr_d = 2'(LOAD_LAT - 1);
            state_d    = LOAD_STALL;
          end
        end
      end
      LOAD_STALL: begin
        hold_pc    = 1'b1;
        hold_ifid  = 1'b1;
        flush_idex = 1'b1;
        if (mem_wait) begin
          // Memory stall freezes the bubble count so load latency is not eaten by it.
          hold_exme  = 1'b1;
          flush_mewb = 1'b1;
        end else begin
          load_ctr_d = load_ctr_q - 2'd1;
          if (load_ctr_q == 2'd1) begin
            state_d = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          hold_pc    = 1'b1;
          hold_ifid  = 1'b1;
          hold_idex  = 1'b1;
          hold_exme  = 1'b1;
          flush_mewb = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      hold_pc    = 1'b0;
      hold_ifid  = 1'b0;
      hold_idex  = 1'b0;
      hold_exme  = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      flush_mewb = 1'b0;
      flush_evt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      load_ctr_q  <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ctr_q <= load_ctr_d;
      if (hold_pc) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
